// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer slice.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } btn_state_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-stage synchronizer that brings the raw button pin into the btn_clk domain.
module btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic btn_clk,
  input  logic btn_rst_n,
  input  logic btn_in,
  output logic sync
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge btn_clk or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign sync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debouncer.sv
// Debounces a synchronized push-button into a clean level plus one-cycle
// press, release and long-press events.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int TICK_DIV     = 100_000,
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic btn_clk,
  input  logic btn_rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam int SW = cnt_width(STABLE_TICKS);
  localparam int LW = cnt_width(LONG_TICKS);

  localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [LW-1:0] LONG_LAST   = LW'(LONG_TICKS - 1);
  localparam logic [LW-1:0] LONG_MAX    = LW'(LONG_TICKS);

  logic       sync;
  btn_state_t state, next_state;

  logic [PW-1:0] pre_cnt, pre_nxt;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic [LW-1:0] long_cnt, long_nxt;
  logic          long_done, long_done_nxt;
  logic          tick, restart;
  logic          press_nxt, release_nxt, long_fire;

  btn_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .btn_clk  (btn_clk),
    .btn_rst_n(btn_rst_n),
    .btn_in   (btn_in),
    .sync     (sync)
  );

  assign tick = (pre_cnt == PRE_LAST);

  // A sync change is checked before the tick, so a bounce on the final tick rejects the edge.
  always_comb begin
    next_state  = state;
    stable_nxt  = stable_cnt;
    restart     = 1'b0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      LOW: begin
        if (sync) begin
          next_state = RISE_CHK;
          stable_nxt = '0;
          restart    = 1'b1;
        end
      end
      RISE_CHK: begin
        if (!sync) begin
          next_state = LOW;
        end else if (tick) begin
          if (stable_cnt == STABLE_LAST) begin
            next_state = HIGH;
            press_nxt  = 1'b1;
          end else begin
            stable_nxt = stable_cnt + 1'b1;
          end
        end
      end
      HIGH: begin
        if (!sync) begin
          next_state = FALL_CHK;
          stable_nxt = '0;
          restart    = 1'b1;
        end
      end
      FALL_CHK: begin
        if (sync) begin
          next_state = HIGH;
        end else if (tick) begin
          if (stable_cnt == STABLE_LAST) begin
            next_state  = LOW;
            release_nxt = 1'b1;
          end else begin
            stable_nxt = stable_cnt + 1'b1;
          end
        end
      end
      default: next_state = LOW;
    endcase

    pre_nxt = (restart || tick) ? '0 : pre_cnt + 1'b1;
  end

  // Long-press tracking keeps running through a FALL_CHK glitch; only LOW re-arms it.
  always_comb begin
    long_nxt      = long_cnt;
    long_done_nxt = long_done;
    long_fire     = 1'b0;
    if (state == RISE_CHK && next_state == HIGH) begin
      long_nxt = '0;
    end else if ((state == HIGH || state == FALL_CHK) && tick) begin
      if (long_cnt != LONG_MAX) begin
        long_nxt = long_cnt + 1'b1;
      end
      if (long_cnt == LONG_LAST && !long_done) begin
        long_fire     = 1'b1;
        long_done_nxt = 1'b1;
      end
    end
    if (next_state == LOW && state != LOW) begin
      long_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge btn_clk or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      state       <= LOW;
      pre_cnt     <= '0;
      stable_cnt  <= '0;
      long_cnt    <= '0;
      long_done   <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      state       <= next_state;
      pre_cnt     <= pre_nxt;
      stable_cnt  <= stable_nxt;
      long_cnt    <= long_nxt;
      long_done   <= long_done_nxt;
      btn_level   <= (next_state == HIGH) || (next_state == FALL_CHK);
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_long    <= long_fire;
    end
  end

endmodule
